transform_pipe: RTL and testbench

TRANSFORM_PIPE -- requirements
Module: transform_pipe

---
 rtl/transform_pipe_if.sv | 37 +++
 rtl/transform_pipe.sv | 176 +++++++++++++++++
 tb/tb_transform_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/transform_pipe_if.sv
// Point-stream handshake bundle for transform_pipe.
// The master side produces points and consumes addresses; the slave is the pipeline.
interface transform_pipe_if #(
    parameter int CW = 8,
    parameter int AW = 16
);
    logic          IN_VALID;
    logic          IN_READY;
    logic [CW-1:0] Xcoord;
    logic [CW-1:0] Ycoord;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [AW-1:0] Addr;
    logic          Write;

    modport master (
        output IN_VALID,
        output Xcoord,
        output Ycoord,
        output OUT_READY,
        input  IN_READY,
        input  OUT_VALID,
        input  Addr,
        input  Write
    );

    modport slave (
        input  IN_VALID,
        input  Xcoord,
        input  Ycoord,
        input  OUT_READY,
        output IN_READY,
        output OUT_VALID,
        output Addr,
        output Write
    );
endinterface

// File: rtl/transform_pipe.sv
// Five-stage point transform: shift, rotate, zoom, clip, framebuffer address.
// The whole pipe moves in lockstep whenever the output slot is free or drained.
module transform_pipe #(
    parameter int CW    = 8,
    parameter int ZF    = 4,
    parameter int SCR_W = 160,
    parameter int SCR_H = 120,
    parameter int AW    = 16
) (
    input  logic            ACLK,
    input  logic            ARESETn,
    input  logic            CFG_LOAD,
    input  logic [CW-1:0]   Xcenter,
    input  logic [CW-1:0]   Ycenter,
    input  logic [CW-1:0]   Zoom,
    input  logic [CW-1:0]   Cos,
    input  logic [CW-1:0]   Sin,
    transform_pipe_if.slave bus,
    output logic            BUSY,
    output logic            CFG_ERR,
    output logic [15:0]     CLIP_CNT
);

    localparam int DW = CW + 1;
    localparam int RW = 2 * CW + 2;
    localparam int ZW = RW + CW + 1;

    localparam logic signed [ZW-1:0] HALF_W = ZW'(SCR_W / 2);
    localparam logic signed [ZW-1:0] HALF_H = ZW'(SCR_H / 2);
    localparam logic signed [ZW-1:0] LIM_W  = ZW'(SCR_W);
    localparam logic signed [ZW-1:0] LIM_H  = ZW'(SCR_H);
    localparam logic [AW-1:0]        ROW_W  = AW'(SCR_W);

    localparam logic [CW-1:0] XC_RST   = CW'(SCR_W / 2);
    localparam logic [CW-1:0] YC_RST   = CW'(SCR_H / 2);
    localparam logic [CW-1:0] ZOOM_RST = CW'(1 << ZF);
    localparam logic [CW-1:0] COS_RST  = CW'(1 << (CW - 2));

    logic [4:0]           vld_q, vld_d;
    logic [CW-1:0]        xc_q, xc_d;
    logic [CW-1:0]        yc_q, yc_d;
    logic [CW-1:0]        zoom_q, zoom_d;
    logic [CW-1:0]        cos_q, cos_d;
    logic [CW-1:0]        sin_q, sin_d;
    logic signed [DW-1:0] xs_q, xs_d;
    logic signed [DW-1:0] ys_q, ys_d;
    logic signed [RW-1:0] xr_q, xr_d;
    logic signed [RW-1:0] yr_q, yr_d;
    logic signed [ZW-1:0] xz_q, xz_d;
    logic signed [ZW-1:0] yz_q, yz_d;
    logic [AW-1:0]        sx_q, sx_d;
    logic [AW-1:0]        sy_q, sy_d;
    logic                 on_q, on_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic                 wr_q, wr_d;
    logic                 cfg_err_q, cfg_err_d;
    logic [15:0]          clip_q, clip_d;

    logic                 advance;
    logic                 busy;
    logic                 cfg_ok;
    logic signed [ZW-1:0] sx_full;
    logic signed [ZW-1:0] sy_full;

    always_comb begin
        advance   = !vld_q[4] || bus.OUT_READY;
        busy      = |vld_q;
        cfg_ok    = CFG_LOAD && !busy && !bus.IN_VALID;
        sx_full   = xz_q + HALF_W;
        sy_full   = yz_q + HALF_H;

        vld_d     = vld_q;
        xc_d      = xc_q;
        yc_d      = yc_q;
        zoom_d    = zoom_q;
        cos_d     = cos_q;
        sin_d     = sin_q;
        xs_d      = xs_q;
        ys_d      = ys_q;
        xr_d      = xr_q;
        yr_d      = yr_q;
        xz_d      = xz_q;
        yz_d      = yz_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        on_d      = on_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        clip_d    = clip_q;
        cfg_err_d = CFG_LOAD && !cfg_ok;

        // Loads only with an empty pipe, so every point sees one config.
        if (cfg_ok) begin
            xc_d   = Xcenter;
            yc_d   = Ycenter;
            zoom_d = Zoom;
            cos_d  = Cos;
            sin_d  = Sin;
        end

        if (advance) begin
            vld_d  = {vld_q[3:0], bus.IN_VALID};
            xs_d   = $signed({1'b0, bus.Xcoord}) - $signed({1'b0, xc_q});
            ys_d   = $signed({1'b0, bus.Ycoord}) - $signed({1'b0, yc_q});
            xr_d   = (RW'(xs_q) * RW'($signed(cos_q))
                    - RW'(ys_q) * RW'($signed(sin_q))) >>> (CW - 2);
            yr_d   = (RW'(xs_q) * RW'($signed(sin_q))
                    + RW'(ys_q) * RW'($signed(cos_q))) >>> (CW - 2);
            xz_d   = (ZW'(xr_q) * ZW'($signed({1'b0, zoom_q}))) >>> ZF;
            yz_d   = (ZW'(yr_q) * ZW'($signed({1'b0, zoom_q}))) >>> ZF;
            sx_d   = AW'(sx_full);
            sy_d   = AW'(sy_full);
            on_d   = !sx_full[ZW-1] && (sx_full < LIM_W)
                  && !sy_full[ZW-1] && (sy_full < LIM_H);
            wr_d   = vld_q[3] && on_q;
            addr_d = (vld_q[3] && on_q) ? (sy_q * ROW_W + sx_q) : '0;
        end

        if (vld_q[4] && bus.OUT_READY && !wr_q && clip_q != 16'hFFFF) begin
            clip_d = clip_q + 16'd1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            vld_q     <= '0;
            xc_q      <= XC_RST;
            yc_q      <= YC_RST;
            zoom_q    <= ZOOM_RST;
            cos_q     <= COS_RST;
            sin_q     <= '0;
            xs_q      <= '0;
            ys_q      <= '0;
            xr_q      <= '0;
            yr_q      <= '0;
            xz_q      <= '0;
            yz_q      <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            on_q      <= 1'b0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            cfg_err_q <= 1'b0;
            clip_q    <= '0;
        end else begin
            vld_q     <= vld_d;
            xc_q      <= xc_d;
            yc_q      <= yc_d;
            zoom_q    <= zoom_d;
            cos_q     <= cos_d;
            sin_q     <= sin_d;
            xs_q      <= xs_d;
            ys_q      <= ys_d;
            xr_q      <= xr_d;
            yr_q      <= yr_d;
            xz_q      <= xz_d;
            yz_q      <= yz_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            on_q      <= on_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            cfg_err_q <= cfg_err_d;
            clip_q    <= clip_d;
        end
    end

    assign bus.IN_READY  = ARESETn && advance;
    assign bus.OUT_VALID = vld_q[4];
    assign bus.Addr      = addr_q;
    assign bus.Write     = wr_q;
    assign BUSY          = busy;
    assign CFG_ERR       = cfg_err_q;
    assign CLIP_CNT      = clip_q;

endmodule

// File: tb/tb_transform_pipe.sv
// Bench for transform_pipe: directed cases plus random streams
// scored against an integer-arithmetic model of the transform.
module tb_transform_pipe;

    localparam int CW    = 8;
    localparam int ZF    = 4;
    localparam int SCR_W = 160;
    localparam int SCR_H = 120;
    localparam int AW    = 16;
    localparam int ONE   = 1 << (CW - 2);
    localparam int ZONE  = 1 << ZF;

    typedef struct {
        int addr;
        bit wr;
        int acc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          cfg_load;
    logic [CW-1:0] cfg_xc;
    logic [CW-1:0] cfg_yc;
    logic [CW-1:0] cfg_zoom;
    logic [CW-1:0] cfg_cos;
    logic [CW-1:0] cfg_sin;
    logic          busy;
    logic          cfg_err;
    logic [15:0]   clip_cnt;

    transform_pipe_if #(.CW(CW), .AW(AW)) bus ();

    transform_pipe #(
        .CW(CW), .ZF(ZF), .SCR_W(SCR_W), .SCR_H(SCR_H), .AW(AW)
    ) dut (
        .ACLK     (clk),
        .ARESETn  (rst_n),
        .CFG_LOAD (cfg_load),
        .Xcenter  (cfg_xc),
        .Ycenter  (cfg_yc),
        .Zoom     (cfg_zoom),
        .Cos      (cfg_cos),
        .Sin      (cfg_sin),
        .bus      (bus),
        .BUSY     (busy),
        .CFG_ERR  (cfg_err),
        .CLIP_CNT (clip_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   n_out    = 0;
    int   m_clip   = 0;
    int   m_xc, m_yc, m_zoom, m_cos, m_sin;
    exp_t q[$];

    bit          last_ix, last_ox, last_in_ready;
    int          last_lat;
    logic [15:0] last_addr;
    logic        last_wr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int fdiv(int a, int d);
        int r;
        r = a / d;
        if ((a % d) != 0 && a < 0) r -= 1;
        return r;
    endfunction

    function automatic void model_cfg_reset();
        m_xc   = SCR_W / 2;
        m_yc   = SCR_H / 2;
        m_zoom = ZONE;
        m_cos  = ONE;
        m_sin  = 0;
    endfunction

    // Shift, rotate, zoom, recentre on screen, then clip and address.
    function automatic exp_t model(int x, int y, int acc);
        exp_t e;
        int xs, ys, xr, yr, sx, sy;
        xs = x - m_xc;
        ys = y - m_yc;
        xr = fdiv(xs * m_cos - ys * m_sin, ONE);
        yr = fdiv(xs * m_sin + ys * m_cos, ONE);
        sx = fdiv(xr * m_zoom, ZONE) + SCR_W / 2;
        sy = fdiv(yr * m_zoom, ZONE) + SCR_H / 2;
        e.wr   = (sx >= 0 && sx < SCR_W && sy >= 0 && sy < SCR_H);
        e.addr = e.wr ? sy * SCR_W + sx : 0;
        e.acc  = acc;
        return e;
    endfunction

    task automatic cycle();
        bit ix, ox, exp_err;
        #1;
        ix = bus.IN_VALID && bus.IN_READY;
        ox = bus.OUT_VALID && bus.OUT_READY;
        if (bus.OUT_READY) chk("in_ready", bus.IN_READY, 1);
        if (bus.OUT_VALID) begin
            if (q.size() == 0) begin
                chk("spurious_valid", bus.OUT_VALID, 0);
            end else begin
                chk("addr", bus.Addr, q[0].addr);
                chk("write", bus.Write, q[0].wr);
            end
        end
        exp_err = cfg_load && (q.size() != 0 || bus.IN_VALID);
        if (ix) q.push_back(model(bus.Xcoord, bus.Ycoord, cyc + 1));
        if (cfg_load && !exp_err) begin
            m_xc   = cfg_xc;
            m_yc   = cfg_yc;
            m_zoom = cfg_zoom;
            m_cos  = int'($signed(cfg_cos));
            m_sin  = int'($signed(cfg_sin));
        end
        last_ix       = ix;
        last_ox       = ox;
        last_in_ready = bus.IN_READY;
        last_addr     = bus.Addr;
        last_wr       = bus.Write;
        @(posedge clk);
        cyc++;
        #1;
        if (ox && q.size() != 0) begin
            last_lat = cyc - q[0].acc;
            if (!q[0].wr && m_clip < 16'hFFFF) m_clip++;
            void'(q.pop_front());
            n_out++;
        end
        chk("cfg_err", cfg_err, exp_err);
        chk("busy", busy, q.size() != 0);
        chk("clip_cnt", clip_cnt, m_clip);
    endtask

    task automatic do_reset(int n);
        rst_n = 1'b0;
        repeat (n) begin
            #1;
            chk("in_ready_rst", bus.IN_READY, 0);
            @(posedge clk);
            cyc++;
            #1;
        end
        q.delete();
        m_clip = 0;
        model_cfg_reset();
        chk("out_valid_rst", bus.OUT_VALID, 0);
        chk("addr_rst", bus.Addr, 0);
        chk("write_rst", bus.Write, 0);
        chk("busy_rst", busy, 0);
        chk("cfg_err_rst", cfg_err, 0);
        chk("clip_rst", clip_cnt, 0);
        rst_n = 1'b1;
        #1;
        chk("in_ready_rel", bus.IN_READY, 1);
    endtask

    task automatic load_cfg(int xc, int yc, int z, int c, int s);
        cfg_xc       = CW'(xc);
        cfg_yc       = CW'(yc);
        cfg_zoom     = CW'(z);
        cfg_cos      = CW'(c);
        cfg_sin      = CW'(s);
        bus.IN_VALID = 1'b0;
        cfg_load     = 1'b1;
        cycle();
        cfg_load     = 1'b0;
    endtask

    task automatic send_one(int x, int y, int ea, bit ew);
        bit got;
        bus.Xcoord    = CW'(x);
        bus.Ycoord    = CW'(y);
        bus.IN_VALID  = 1'b1;
        bus.OUT_READY = 1'b1;
        cycle();
        chk("accept", last_ix, 1);
        bus.IN_VALID = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            if (last_ox) got = 1'b1;
        end
        chk("out_seen", got, 1);
        if (got) begin
            chk("latency", last_lat, 5);
            chk("addr_exp", last_addr, ea);
            chk("write_exp", last_wr, ew);
        end
    endtask

    task automatic drain();
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
        cfg_load      = 1'b0;
        for (int i = 0; i < 40 && q.size() != 0; i++) cycle();
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        int n0, i, t;
        rst_n         = 1'b0;
        cfg_load      = 1'b0;
        cfg_xc        = '0;
        cfg_yc        = '0;
        cfg_zoom      = '0;
        cfg_cos       = '0;
        cfg_sin       = '0;
        bus.IN_VALID  = 1'b0;
        bus.Xcoord    = '0;
        bus.Ycoord    = '0;
        bus.OUT_READY = 1'b1;
        model_cfg_reset();
        @(posedge clk);
        #1;
        do_reset(2);

        // Reset config is the identity about the screen centre.
        send_one(80, 60, 9680, 1'b1);
        send_one(90, 61, 9850, 1'b1);

        load_cfg(100, 80, 16, 64, 0);
        send_one(100, 80, 9680, 1'b1);
        send_one(200, 80, 0, 1'b0);
        chk("clip_one", clip_cnt, 1);

        load_cfg(100, 80, 16, 0, 64);
        send_one(110, 80, 11280, 1'b1);

        load_cfg(100, 80, 32, 64, 0);
        send_one(130, 80, 9740, 1'b1);

        // Eight-point stream with a three-cycle output stall and a rejected load.
        load_cfg(100, 80, 16, 64, 0);
        n0 = n_out;
        i  = 0;
        t  = 0;
        while (i < 8 && t < 50) begin
            bus.Xcoord    = CW'(100 + i * 3);
            bus.Ycoord    = CW'(80 + i);
            bus.IN_VALID  = 1'b1;
            bus.OUT_READY = !(t >= 6 && t <= 8);
            cfg_load      = (t == 3);
            cfg_zoom      = 8'd48;
            cfg_cos       = 8'd0;
            cycle();
            cfg_load = 1'b0;
            if (t >= 6 && t <= 8) chk("in_ready_stall", last_in_ready, 0);
            if (last_ix) i++;
            t++;
        end
        chk("stream_sent", i, 8);
        drain();
        chk("stream_count", n_out - n0, 8);

        // Random configurations and handshake patterns.
        for (int r = 0; r < 4; r++) begin
            int sent, tt;
            load_cfg($urandom_range(60, 190), $urandom_range(40, 200),
                     $urandom_range(4, 48), $urandom_range(0, 255),
                     $urandom_range(0, 255));
            sent = 0;
            tt   = 0;
            while (sent < 60 && tt < 600) begin
                bus.Xcoord    = CW'(m_xc + $urandom_range(0, 60) - 30);
                bus.Ycoord    = CW'(m_yc + $urandom_range(0, 60) - 30);
                bus.IN_VALID  = ($urandom_range(0, 3) != 0);
                bus.OUT_READY = ($urandom_range(0, 9) < 7);
                cfg_load      = ($urandom_range(0, 24) == 0);
                cfg_xc        = CW'($urandom_range(60, 190));
                cfg_yc        = CW'($urandom_range(40, 200));
                cfg_zoom      = CW'($urandom_range(4, 48));
                cfg_cos       = CW'($urandom_range(0, 255));
                cfg_sin       = CW'($urandom_range(0, 255));
                cycle();
                cfg_load = 1'b0;
                if (last_ix) sent++;
                tt++;
            end
            chk("rand_sent", sent, 60);
            drain();
        end

        // Reset with three points in flight.
        load_cfg(100, 80, 32, 0, 64);
        bus.OUT_READY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.Xcoord   = CW'(100 + k);
            bus.Ycoord   = CW'(80 + k);
            bus.IN_VALID = 1'b1;
            cycle();
        end
        bus.IN_VALID = 1'b0;
        do_reset(1);
        n0 = n_out;
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("no_valid_after_rst", bus.OUT_VALID, 0);
        end
        chk("no_out_after_rst", n_out - n0, 0);
        send_one(90, 60, 9690, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
